spiflash_reader: RTL
====================

Name: spiflash_reader

Overview:
- Single-bit SPI flash read initiator for the hardware top level.
- Drives the off-chip serial flash pins and wakes the flash after reset.
- For each accepted word request, issues a READ (0x03) transaction and returns 32 bits little-endian.
- Sits between the CPU instruction/data fetch path and the flash pins; drop-in pin-compatible with the spiflash simulation model.

Parameters:
- CLK_DIV, 1: SPI half-period in clk cycles (>=1); one SPI bit = 2*CLK_DIV clk cycles.
- CSB_GAP, 2: minimum clk cycles flash_csb stays high between transactions (>=1).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  read request
- req_ready  out  1  request accepted when req_valid && req_ready at clk edge
- req_addr  in  24  flash byte address of first byte
- rsp_valid  out  1  one-cycle pulse, rsp_data valid; no backpressure
- rsp_data  out  32  read word, first byte in [7:0]
- flash_csb  out  1  chip select, active low
- flash_clk  out  1  SPI clock, idle low (mode 0)
- flash_io0  out  1  MOSI
- flash_io1  in  1  MISO

Behaviour:
- Reset (async, resetn=0):
  - flash_csb=1, flash_clk=0, flash_io0=0.
  - req_ready=0, rsp_valid=0, rsp_data=0.
  - State=WAKE.
  - Reset mid-transaction aborts immediately (csb rises asynchronously); the wake sequence reruns on release.
- States:
  - WAKE: shift out 0xAB (8 bits) -> GAP.
  - GAP: csb high, count CSB_GAP cycles -> IDLE.
  - IDLE: req_ready=1. On accept, latch req_addr -> CMD.
  - CMD: 8 bits 0x03 -> ADDR.
  - ADDR: 24 bits, addr[23] first -> DATA.
  - DATA: 32 bits -> DONE.
  - DONE: one cycle, rsp_valid=1 -> GAP.
- req_ready is 1 only in IDLE. req_valid outside IDLE is ignored; the requester holds it.
- Bit timing, accept at cycle T:
  - First bit occupies T+1..T+2*CLK_DIV. Bit i occupies T+1+2*CLK_DIV*i .. T+2*CLK_DIV*(i+1).
  - Each bit: flash_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - flash_io0 changes only at the start of a bit (while flash_clk is low). MSB first within each byte.
  - flash_csb goes low at T+1 and stays low through the end of the last DATA bit.
- MISO capture: flash_io1 is registered on the clk edge that raises flash_clk, during DATA bits only.
- rsp_data assembly:
  - Byte k (k=0..3, in received order) goes to rsp_data[8k+7:8k], MSB first within the byte.
  - rsp_data holds its value until the next DONE.
- Latency: rsp_valid is high at exactly cycle T+1+128*CLK_DIV.
  - In that same cycle, flash_csb=1 and flash_clk=0.
  - Next possible accept is at T+1+128*CLK_DIV+CSB_GAP (req_ready high from the cycle after DONE+CSB_GAP-1).
- The wake transaction is 16*CLK_DIV cycles of csb low, followed by GAP.
  - First req_ready=1 is at cycle 1+16*CLK_DIV+CSB_GAP after resetn deasserts.
- Address wrap is the flash's concern; the block transmits the address verbatim.
- Divider counter width: $clog2(CLK_DIV)+1. Bit counter: 6 bits, reloaded per phase (8/24/32).

Decomposition:
- Package spiflash_pkg holds:
  - constants CMD_READ=8'h03, CMD_WAKE=8'hAB;
  - the state enum (WAKE, GAP, IDLE, CMD, ADDR, DATA, DONE).
- One sub-module, spiflash_bitengine. It:
  - loads up to 32 bits plus a bit count;
  - generates flash_clk with CLK_DIV;
  - shifts io0 out and captures io1 in;
  - pulses done at the end of the last bit.
- The FSM in spiflash_reader sequences the engine.

Test Plan:
- Reset release, CLK_DIV=1:
  - flash_io0 carries 10101011 over 8 SPI bits, csb low for 16 cycles.
  - req_ready first high at cycle 19 after resetn rises.
- Model preloaded mem[i]=i[7:0]; request addr 0x000004:
  - MOSI stream = 0x03,0x00,0x00,0x04.
  - rsp_data=0x07060504, rsp_valid exactly 129 cycles after accept, one cycle wide.
- Same preload, addr 0xFFFFFE -> rsp_data=0x0100FFFE (flash wrap), address bits sent verbatim.
- Back-to-back requests with req_valid held high, addrs 0x000000 then 0x000010:
  - Second accept occurs exactly CSB_GAP=2 cycles after the first rsp_valid.
  - Responses 0x03020100, 0x13121110.
- CLK_DIV=3:
  - flash_clk high/low phases each 3 cycles.
  - rsp_valid at accept+385; data is correct.
- Assert resetn=0 mid-ADDR phase:
  - flash_csb=1 and flash_clk=0 without waiting for a clk edge, rsp_valid never pulses.
  - After release, the wake byte 0xAB reappears and a subsequent read returns correct data.

Source files
------------

// File: rtl/spiflash_pkg.sv
// Shared constants, state encoding and byte-order helper for the SPI flash read initiator.
package spiflash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WAKE = 8'hAB;

  typedef logic [2:0] state_t;

  localparam state_t ST_WAKE = 3'd0;
  localparam state_t ST_GAP  = 3'd1;
  localparam state_t ST_IDLE = 3'd2;
  localparam state_t ST_CMD  = 3'd3;
  localparam state_t ST_ADDR = 3'd4;
  localparam state_t ST_DATA = 3'd5;
  localparam state_t ST_DONE = 3'd6;

  // Serial data arrives first byte in [31:24]; the response wants it in [7:0].
  function automatic logic [31:0] byte_rev32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spiflash_bitengine.sv
// Mode-0 SPI bit shifter: up to 32 bits MSB first, CLK_DIV clk cycles per SCK half.
// A start on the done cycle chains the next field seamlessly with csb held low.
module spiflash_bitengine
  import spiflash_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] tx_bits,
  input  logic [5:0]  nbits,
  input  logic        capture,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_bits,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          busy_q;
  logic          csb_q;
  logic          sclk_q;
  logic [31:0]   shreg;
  logic [5:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [31:0]   rx_q;
  logic          half_end;

  assign half_end = busy_q && (div_cnt == DIV_LAST);
  assign done     = half_end && sclk_q && (bit_cnt == 6'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q  <= 1'b0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      rx_q    <= '0;
    end else if (start) begin
      busy_q  <= 1'b1;
      csb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      shreg   <= tx_bits;
      bit_cnt <= nbits;
      div_cnt <= '0;
    end else if (busy_q) begin
      if (!half_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!sclk_q) begin
          // Rising SCK: the flash has had a full low half to settle MISO.
          sclk_q <= 1'b1;
          if (capture) rx_q <= {rx_q[30:0], flash_io1};
        end else begin
          sclk_q <= 1'b0;
          if (bit_cnt == 6'd1) begin
            busy_q <= 1'b0;
            csb_q  <= 1'b1;
            shreg  <= '0;
          end else begin
            shreg   <= {shreg[30:0], 1'b0};
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
      end
    end
  end

  assign busy      = busy_q;
  assign rx_bits   = rx_q;
  assign flash_csb = csb_q;
  assign flash_clk = sclk_q;
  assign flash_io0 = shreg[31];

endmodule

// File: rtl/spiflash_reader.sv
// SPI flash READ initiator: wakes the flash after reset, then serves one 32-bit word per request.
// rsp_valid pulses 1+128*CLK_DIV cycles after accept; req_ready only in IDLE, responses have no backpressure.
module spiflash_reader
  import spiflash_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CSB_GAP = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam int GW = $clog2(CSB_GAP + 1) + 1;
  // The DONE cycle already has csb high, so it counts toward the gap after a read.
  localparam logic [GW-1:0] GAP_WAKE = GW'(CSB_GAP - 1);
  localparam logic [GW-1:0] GAP_DONE = GW'((CSB_GAP >= 2) ? (CSB_GAP - 2) : 0);

  state_t        state;
  logic [23:0]   addr_q;
  logic [GW-1:0] gap_cnt;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;

  logic          eng_start;
  logic [31:0]   eng_tx;
  logic [5:0]    eng_nbits;
  logic          eng_busy;
  logic          eng_done;
  logic [31:0]   eng_rx;

  always_comb begin
    eng_start = 1'b0;
    eng_tx    = '0;
    eng_nbits = '0;
    case (state)
      ST_WAKE: begin
        eng_start = !eng_busy;
        eng_tx    = {CMD_WAKE, 24'h0};
        eng_nbits = 6'd8;
      end
      ST_IDLE: begin
        eng_start = req_valid;
        eng_tx    = {CMD_READ, 24'h0};
        eng_nbits = 6'd8;
      end
      ST_CMD: begin
        eng_start = eng_done;
        eng_tx    = {addr_q, 8'h00};
        eng_nbits = 6'd24;
      end
      ST_ADDR: begin
        eng_start = eng_done;
        eng_tx    = 32'h0;
        eng_nbits = 6'd32;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_WAKE;
      addr_q      <= '0;
      gap_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_WAKE: if (eng_done) begin
          state   <= ST_GAP;
          gap_cnt <= GAP_WAKE;
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        ST_IDLE: if (req_valid) begin
          state  <= ST_CMD;
          addr_q <= req_addr;
        end
        ST_CMD:  if (eng_done) state <= ST_ADDR;
        ST_ADDR: if (eng_done) state <= ST_DATA;
        ST_DATA: if (eng_done) begin
          state       <= ST_DONE;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= byte_rev32(eng_rx);
        end
        ST_DONE: begin
          if (CSB_GAP == 1) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_GAP;
            gap_cnt <= GAP_DONE;
          end
        end
        default: state <= ST_WAKE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  spiflash_bitengine #(
    .CLK_DIV (CLK_DIV)
  ) u_bitengine (
    .clk       (clk),
    .resetn    (resetn),
    .start     (eng_start),
    .tx_bits   (eng_tx),
    .nbits     (eng_nbits),
    .capture   (state == ST_DATA),
    .busy      (eng_busy),
    .done      (eng_done),
    .rx_bits   (eng_rx),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .flash_io0 (flash_io0),
    .flash_io1 (flash_io1)
  );

endmodule
